// File: rtl/slot_player.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slot_player: coin credit balance, one-cycle lever pull, win payout.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module slot_player #(
   parameter int          CREDIT_W       = 8,
   parameter int          WIN_PAYOUT     = 5,
   parameter logic [2:0]  WIN_CODE       = 3'b111,
   parameter int          RESULT_TIMEOUT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                coin,
   input  logic                play,
   input  logic [2:0]          display,
   output logic                lever,
   output logic                busy,
   output logic                done,
   output logic                win,
   output logic [CREDIT_W-1:0] credits,
   output logic [CREDIT_W-1:0] win_count
);

   localparam int                  c_CNT_W  = $clog2(RESULT_TIMEOUT);
   localparam logic [c_CNT_W-1:0]  c_LAST   = c_CNT_W'(RESULT_TIMEOUT - 1);
   localparam logic [CREDIT_W:0]   c_PAYOUT = (CREDIT_W + 1)'(WIN_PAYOUT);
   localparam logic [CREDIT_W-1:0] c_MAX    = {CREDIT_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PULL = 3'd1,
      S_WAIT = 3'd2,
      S_PAY  = 3'd3,
      S_LOSE = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [c_CNT_W-1:0]  r_wait_cnt;
   logic [c_CNT_W-1:0]  w_next_cnt;
   logic [CREDIT_W-1:0] r_credits;
   logic [CREDIT_W-1:0] r_win_count;
   logic                w_debit;
   logic [CREDIT_W:0]   w_sum;

   // Debit is judged on the pre-update balance, so a same-cycle coin cannot fund a play.
   assign w_debit = (r_state == S_IDLE) && play && (r_credits != '0);

   assign w_sum = {1'b0, r_credits}
                + {{CREDIT_W{1'b0}}, coin}
                - {{CREDIT_W{1'b0}}, w_debit}
                + ((r_state == S_PAY) ? c_PAYOUT : '0);

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_wait_cnt;
      case (r_state)
         S_IDLE: if (w_debit) w_next_state = S_PULL;
         S_PULL: begin
            w_next_cnt   = '0;
            w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (display == WIN_CODE) begin
               w_next_state = S_PAY;
            end else if (r_wait_cnt == c_LAST) begin
               w_next_state = S_LOSE;
            end else begin
               w_next_cnt = r_wait_cnt + c_CNT_W'(1);
            end
         end
         S_PAY:   w_next_state = S_IDLE;
         S_LOSE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_wait_cnt  <= '0;
         r_credits   <= '0;
         r_win_count <= '0;
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= w_next_cnt;
         r_credits  <= w_sum[CREDIT_W] ? c_MAX : w_sum[CREDIT_W-1:0];
         if ((r_state == S_PAY) && (r_win_count != c_MAX)) begin
            r_win_count <= r_win_count + CREDIT_W'(1);
         end
      end
   end

   assign lever     = (r_state == S_PULL);
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_PAY) || (r_state == S_LOSE);
   assign win       = (r_state == S_PAY);
   assign credits   = r_credits;
   assign win_count = r_win_count;

endmodule
`default_nettype wire

// File: tb/tb_slot_player.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_slot_player: directed and random spins against a timeline model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_slot_player;

   localparam int         c_T     = 4;
   localparam int         c_PAY   = 5;
   localparam int         c_MAXV  = 255;
   localparam logic [2:0] c_WCODE = 3'b111;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       coin = 1'b0;
   logic       play = 1'b0;
   logic [2:0] display = 3'b000;
   logic       lever, busy, done, win;
   logic [7:0] credits, win_count;

   int n_cmp = 0;
   int n_err = 0;
   int lever_cnt = 0;

   // Model: balance, wins, and position on the spin timeline (age 1 = lever cycle,
   // ages 2.. = waiting; res marks the scoring cycle as 1 = win, 2 = loss).
   int m_credits = 0;
   int m_wins = 0;
   bit m_active = 0;
   int m_age = 0;
   int m_res = 0;

   slot_player #(
      .CREDIT_W(8), .WIN_PAYOUT(c_PAY), .WIN_CODE(c_WCODE), .RESULT_TIMEOUT(c_T)
   ) dut (
      .clk(clk), .reset(reset), .coin(coin), .play(play), .display(display),
      .lever(lever), .busy(busy), .done(done), .win(win),
      .credits(credits), .win_count(win_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_credits = 0; m_wins = 0; m_active = 0; m_age = 0; m_res = 0;
   endtask

   task automatic model_edge(input logic c, input logic p, input logic [2:0] d);
      int nc;
      bit debit;
      bit win_now;
      win_now = m_active && (m_res == 1);
      debit   = !m_active && p && (m_credits >= 1);
      nc = m_credits + int'(c) - int'(debit) + (win_now ? c_PAY : 0);
      if (nc > c_MAXV) nc = c_MAXV;
      if (win_now && m_wins < c_MAXV) m_wins++;
      if (!m_active) begin
         if (debit) begin m_active = 1; m_age = 1; m_res = 0; end
      end else if (m_res != 0) begin
         m_active = 0; m_res = 0;
      end else if (m_age == 1) begin
         m_age = 2;
      end else if (d == c_WCODE) begin
         m_res = 1;
      end else if (m_age - 2 == c_T - 1) begin
         m_res = 2;
      end else begin
         m_age++;
      end
      m_credits = nc;
   endtask

   task automatic check_all();
      chk("lever", 32'(lever), 32'(m_active && m_age == 1 && m_res == 0));
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_res != 0));
      chk("win", 32'(win), 32'(m_res == 1));
      chk("credits", 32'(credits), 32'(m_credits));
      chk("win_count", 32'(win_count), 32'(m_wins));
   endtask

   task automatic step(input logic c, input logic p, input logic [2:0] d);
      @(negedge clk);
      coin = c; play = p; display = d;
      @(posedge clk);
      model_edge(c, p, d);
      #1;
      check_all();
      if (lever === 1'b1) lever_cnt++;
   endtask

   initial begin
      // Power-up reset
      #2 reset = 1'b1;
      #1 model_reset();
      check_all();
      @(negedge clk) reset = 1'b0;

      // Play with zero credits is dropped; coin+play from zero only adds the coin
      step(0, 1, 3'b000);
      step(1, 1, 3'b000);
      step(0, 0, 3'b000);
      chk("zero_credit_lever", 32'(lever_cnt), 32'd0);
      chk("zero_credit_bal", 32'(credits), 32'd1);

      // Loss: balance 2, play, display 010 then 000
      step(1, 0, 3'b000);
      lever_cnt = 0;
      step(0, 1, 3'b000);
      chk("loss_debit", 32'(credits), 32'd1);
      step(0, 0, 3'b010);
      for (int i = 0; i < 6; i++) step(0, 0, 3'b000);
      chk("loss_lever_once", 32'(lever_cnt), 32'd1);
      chk("loss_wins", 32'(win_count), 32'd0);

      // Win from a single credit, WIN_CODE held for two cycles
      step(0, 1, 3'b000);
      step(0, 0, 3'b000);
      step(0, 0, c_WCODE);
      chk("win_done", 32'(done), 32'd1);
      step(0, 0, c_WCODE);
      chk("win_bal", 32'(credits), 32'd5);
      chk("win_count1", 32'(win_count), 32'd1);
      step(0, 0, 3'b000);
      chk("win_single_pay", 32'(win_count), 32'd1);

      // coin+play together at credit 5 keeps the balance; this spin is lost
      step(1, 1, 3'b000);
      chk("coinplay_bal", 32'(credits), 32'd5);
      for (int i = 0; i < 6; i++) step(0, 0, 3'b000);

      // Coin during PAY at balance 4 lands 4+5+1
      step(0, 1, 3'b000);
      step(0, 0, 3'b000);
      step(0, 0, c_WCODE);
      step(1, 0, 3'b000);
      chk("pay_plus_coin", 32'(credits), 32'd10);

      // Saturation: climb to 254, win with a coin during PAY
      for (int i = 0; i < 244; i++) step(1, 0, 3'b000);
      chk("bal_254", 32'(credits), 32'd254);
      step(0, 1, 3'b000);
      step(0, 0, 3'b000);
      step(0, 0, c_WCODE);
      step(1, 0, 3'b000);
      chk("saturate", 32'(credits), 32'd255);

      // play pulses while waiting are ignored
      lever_cnt = 0;
      step(0, 1, 3'b000);
      step(0, 0, 3'b000);
      for (int i = 0; i < 5; i++) step(0, 1, 3'b000);
      step(0, 0, 3'b000);
      chk("busy_play_ignored", 32'(lever_cnt), 32'd1);

      // Asynchronous reset in the middle of WAIT with balance 3
      @(negedge clk) reset = 1'b1;
      #1 model_reset();
      @(negedge clk) reset = 1'b0;
      for (int i = 0; i < 4; i++) step(1, 0, 3'b000);
      step(0, 1, 3'b000);
      step(0, 0, 3'b000);
      step(0, 0, 3'b000);
      chk("pre_reset_bal", 32'(credits), 32'd3);
      chk("pre_reset_busy", 32'(busy), 32'd1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_credits", 32'(credits), 32'd0);
      model_reset();
      check_all();
      @(negedge clk) reset = 1'b0;
      step(0, 0, 3'b000);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 3) == 0) ? c_WCODE : 3'($urandom_range(0, 6)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
